// File: rtl/ni_window_gen.sv
// Window accumulator feeding the NIRD neighbourhood-intensity comparator.
// Define NI_WINDOW_SAT_EN to saturate sum_o instead of wrapping it.
module ni_window_gen #(
    parameter int WIDTH   = 10,
    parameter int WIN_LEN = 9,
    parameter int CENTER  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sof_i,
    input  logic             valid_i,
    input  logic [7:0]       pix_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [23:0]      S_o,
    output logic             ovf_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int ACC_W = WIDTH + 8;
    localparam logic [7:0] LAST = 8'(WIN_LEN - 1);
    localparam logic [7:0] CTR  = 8'(CENTER);
    localparam logic [ACC_W-1:0] SUM_MAX = {{8{1'b0}}, {WIDTH{1'b1}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       ctr_q, ctr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [23:0]      s_q, s_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [7:0]       eff_idx;
    logic [ACC_W-1:0] eff_acc;
    logic [ACC_W-1:0] total;
    logic [7:0]       centre;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        ctr_d   = ctr_q;
        sum_d   = sum_q;
        s_d     = s_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        // sof_i clears the partial window before the current pixel lands
        eff_idx = sof_i ? '0 : idx_q;
        eff_acc = sof_i ? '0 : acc_q;
        total   = eff_acc + ACC_W'(pix_i);
        centre  = (CENTER == WIN_LEN - 1) ? pix_i : ctr_q;
        if (sof_i) begin
            state_d = IDLE;
            idx_d   = '0;
            acc_d   = '0;
        end
        if (valid_i) begin
            if (eff_idx == CTR) ctr_d = pix_i;
            unique case (1'b1)
                (eff_idx == 8'd0): begin
                    acc_d   = ACC_W'(pix_i);
                    idx_d   = 8'd1;
                    state_d = ACCUM;
                end
                (eff_idx == LAST): begin
`ifdef NI_WINDOW_SAT_EN
                    sum_d = (total > SUM_MAX) ? {WIDTH{1'b1}} : total[WIDTH-1:0];
`else
                    sum_d = total[WIDTH-1:0];
`endif
                    s_d     = {centre, 16'h0000};
                    ovf_d   = (total > SUM_MAX);
                    done_d  = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    acc_d = total;
                    idx_d = eff_idx + 8'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            ctr_q   <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            ctr_q   <= ctr_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign sum_o  = sum_q;
    assign S_o    = s_q;
    assign ovf_o  = ovf_q;
    assign done_o = done_q;
    assign busy_o = (state_q == ACCUM);

endmodule

// File: tb/tb_ni_window_gen.sv
// Randomized bench for ni_window_gen against a pixel-queue window model.
// Build with NI_WINDOW_SAT_EN to check the saturating variant.
module tb_ni_window_gen;

    localparam int WIDTH   = 10;
    localparam int WIN_LEN = 9;
    localparam int CENTER  = 4;
    localparam int MAXV    = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sof_i;
    logic             valid_i;
    logic [7:0]       pix_i;
    logic [WIDTH-1:0] sum_o;
    logic [23:0]      S_o;
    logic             ovf_o;
    logic             done_o;
    logic             busy_o;

    ni_window_gen #(.WIDTH(WIDTH), .WIN_LEN(WIN_LEN), .CENTER(CENTER)) dut (
        .clk(clk), .rst_n(rst_n), .sof_i(sof_i), .valid_i(valid_i),
        .pix_i(pix_i), .sum_o(sum_o), .S_o(S_o), .ovf_o(ovf_o),
        .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model: pixels of the current partial window and the expected outputs
    int         win[$];
    logic       exp_done, exp_busy, exp_ovf;
    int         exp_sum;
    logic [23:0] exp_s;

    task automatic model_clear();
        win.delete();
        exp_done = 0; exp_busy = 0; exp_ovf = 0; exp_sum = 0; exp_s = 0;
    endtask

    task automatic run_pix(input logic sof, input logic vld, input int pix);
        int total;
        @(negedge clk);
        sof_i = sof; valid_i = vld; pix_i = 8'(pix);
        @(posedge clk);
        #1;
        cyc++;
        exp_done = 0;
        if (sof) win.delete();
        if (vld) begin
            win.push_back(pix);
            if (win.size() == WIN_LEN) begin
                total = 0;
                foreach (win[k]) total += win[k];
`ifdef NI_WINDOW_SAT_EN
                exp_sum = (total > MAXV) ? MAXV : total;
`else
                exp_sum = total % (MAXV + 1);
`endif
                exp_ovf  = (total > MAXV);
                exp_s    = {8'(win[CENTER]), 16'h0000};
                exp_done = 1;
                win.delete();
            end
        end
        exp_busy = (win.size() != 0);
    endtask

    task automatic idle();
        run_pix(0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 0; sof_i = 0; valid_i = 0; pix_i = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1;
        #1;
        n_checks++;
        if ({done_o, busy_o, ovf_o, sum_o, S_o} !== '0) begin
            n_fail++;
            $display("FAIL reset: done=%b busy=%b ovf=%b sum=%0d S=%h required all 0",
                     done_o, busy_o, ovf_o, sum_o, S_o);
        end
    endtask

    task automatic test_basic();
        int pulses = 0;
        for (int i = 0; i < WIN_LEN + 2; i++) begin
            if (i < WIN_LEN) run_pix(0, 1, 10); else idle();
            if (done_o) pulses++;
            n_checks++;
            if (done_o !== exp_done || busy_o !== exp_busy) begin
                n_fail++;
                $display("FAIL basic_ctl cyc%0d: done=%b busy=%b required %b %b",
                         i, done_o, busy_o, exp_done, exp_busy);
            end
        end
        n_checks++;
        if (pulses != 1 || sum_o !== 10'd90 || S_o !== 24'h0A0000 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_win: pulses=%0d sum=%0d S=%h ovf=%b required 1 90 0a0000 0",
                     pulses, sum_o, S_o, ovf_o);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < WIN_LEN; i++) run_pix(0, 1, 255);
        n_checks++;
`ifdef NI_WINDOW_SAT_EN
        if (done_o !== 1'b1 || sum_o !== 10'd1023 || ovf_o !== 1'b1) begin
`else
        if (done_o !== 1'b1 || sum_o !== 10'd247 || ovf_o !== 1'b1) begin
`endif
            n_fail++;
            $display("FAIL ovf_win: done=%b sum=%0d ovf=%b required done 1 sum %0d ovf 1",
                     done_o, sum_o, ovf_o, exp_sum);
        end
        idle();
        n_checks++;
        if (done_o !== 1'b0 || ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold: done=%b ovf=%b required 0 1", done_o, ovf_o);
        end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 2 * WIN_LEN; i++) begin
            run_pix(0, (i % 2) == 0, i / 2);
            n_checks++;
            if (done_o !== exp_done || busy_o !== exp_busy) begin
                n_fail++;
                $display("FAIL gap_ctl step%0d: done=%b busy=%b required %b %b",
                         i, done_o, busy_o, exp_done, exp_busy);
            end
        end
        n_checks++;
        if (sum_o !== 10'd36 || S_o !== 24'h040000) begin
            n_fail++;
            $display("FAIL gap_win: sum=%0d S=%h required 36 040000", sum_o, S_o);
        end
    endtask

    task automatic test_sof();
        int pulses = 0;
        for (int i = 0; i < 5; i++) run_pix(0, 1, $urandom_range(0, 255));
        run_pix(1, 1, 1);
        if (done_o) pulses++;
        for (int i = 0; i < 8; i++) begin
            run_pix(0, 1, 1);
            if (done_o) pulses++;
        end
        n_checks++;
        if (pulses != 1 || done_o !== 1'b1 || sum_o !== 10'd9 || S_o !== 24'h010000) begin
            n_fail++;
            $display("FAIL sof_win: pulses=%0d done=%b sum=%0d S=%h required 1 1 9 010000",
                     pulses, done_o, sum_o, S_o);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        int t[$];
        for (int i = 0; i < 2 * WIN_LEN + 1; i++) begin
            if (i < 2 * WIN_LEN) run_pix(0, 1, $urandom_range(0, 255)); else idle();
            if (done_o) t.push_back(cyc);
            n_checks++;
            if (done_o !== exp_done || busy_o !== exp_busy ||
                (exp_done && (sum_o !== 10'(exp_sum) || S_o !== exp_s || ovf_o !== exp_ovf))) begin
                n_fail++;
                $display("FAIL b2b step%0d: done=%b sum=%0d S=%h ovf=%b required %b %0d %h %b",
                         i, done_o, sum_o, S_o, ovf_o, exp_done, exp_sum, exp_s, exp_ovf);
            end
        end
        n_checks++;
        if (t.size() != 2 || (t.size() == 2 && t[1] - t[0] != WIN_LEN)) begin
            n_fail++;
            $display("FAIL b2b_spacing: pulses=%0d required 2 pulses %0d apart",
                     t.size(), WIN_LEN);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) run_pix(0, 1, 200);
        @(negedge clk);
        valid_i = 0; sof_i = 0;
        #2 rst_n = 0;
        #1;
        model_clear();
        n_checks++;
        if ({done_o, busy_o, ovf_o, sum_o, S_o} !== '0) begin
            n_fail++;
            $display("FAIL async_rst: done=%b busy=%b ovf=%b sum=%0d S=%h required all 0",
                     done_o, busy_o, ovf_o, sum_o, S_o);
        end
        @(negedge clk); rst_n = 1;
        begin
            int pulses = 0;
            for (int i = 0; i < WIN_LEN + 1; i++) begin
                if (i < WIN_LEN) run_pix(0, 1, $urandom_range(0, 120)); else idle();
                if (done_o) pulses++;
                n_checks++;
                if (done_o !== exp_done ||
                    (exp_done && (sum_o !== 10'(exp_sum) || S_o !== exp_s))) begin
                    n_fail++;
                    $display("FAIL post_rst step%0d: done=%b sum=%0d S=%h required %b %0d %h",
                             i, done_o, sum_o, S_o, exp_done, exp_sum, exp_s);
                end
            end
            n_checks++;
            if (pulses != 1) begin
                n_fail++;
                $display("FAIL post_rst_pulses: got %0d required 1", pulses);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            run_pix($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 255));
            n_checks++;
            if (done_o !== exp_done || busy_o !== exp_busy || sum_o !== 10'(exp_sum) ||
                S_o !== exp_s || ovf_o !== exp_ovf) begin
                n_fail++;
                $display("FAIL rand step%0d: done=%b busy=%b sum=%0d S=%h ovf=%b required %b %b %0d %h %b",
                         i, done_o, busy_o, sum_o, S_o, ovf_o,
                         exp_done, exp_busy, exp_sum, exp_s, exp_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_gapped();
        test_sof();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
